// File: rtl/plab2_proc_imem_fetch_tracker.sv
// plab2_proc_imem_fetch_tracker
//
// Tracks outstanding instruction fetches between the fetch control and the
// instruction-memory ports. It allows up to p_max_inflight credits, where a
// credit is an outstanding request or a buffered response. It discards
// responses that belong to squashed fetches. Live responses go through a
// bypass queue. A change of security domain squashes every older fetch.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   domain_i                security domain of the fetch stream
//   squash_i                redirect; kills every fetch issued before this cycle
//   creq_val_i / creq_rdy_o fetch issue handshake from ctrl
//   mreq_val_o / mreq_rdy_i request handshake to imem
//   mresp_*                 response handshake from imem
//   cresp_*                 live response handshake to ctrl
//   inflight_o              requests issued whose response has not been received
//   drop_pending_o          responses still to be discarded
module plab2_proc_imem_fetch_tracker #(
    parameter int unsigned p_msg_nbits    = 32,
    parameter int unsigned p_max_inflight = 4,
    parameter int unsigned p_cnt_nbits    = $clog2(p_max_inflight + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   domain_i,
    input  logic                   squash_i,
    input  logic                   creq_val_i,
    output logic                   creq_rdy_o,
    output logic                   mreq_val_o,
    input  logic                   mreq_rdy_i,
    input  logic [p_msg_nbits-1:0] mresp_msg_i,
    input  logic                   mresp_val_i,
    output logic                   mresp_rdy_o,
    output logic [p_msg_nbits-1:0] cresp_msg_o,
    output logic                   cresp_val_o,
    input  logic                   cresp_rdy_i,
    output logic [p_cnt_nbits-1:0] inflight_o,
    output logic [p_cnt_nbits-1:0] drop_pending_o
);

    localparam int unsigned PtrW  = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam int unsigned UsedW = p_cnt_nbits + 1;
    localparam logic [UsedW-1:0]       MaxUsed = UsedW'(p_max_inflight);
    localparam logic [p_cnt_nbits-1:0] MaxCnt  = p_cnt_nbits'(p_max_inflight);
    localparam logic [PtrW-1:0]        LastPtr = PtrW'(p_max_inflight - 1);
    localparam logic [PtrW-1:0]        PtrOne  = PtrW'(1);

    logic                   dom_q;
    logic [p_cnt_nbits-1:0] inflight_q, inflight_d;
    logic [p_cnt_nbits-1:0] drop_q, drop_d;
    logic [p_cnt_nbits-1:0] occ_q, occ_d;
    logic [PtrW-1:0]        head_q, head_d;
    logic [PtrW-1:0]        tail_q, tail_d;
    logic [p_msg_nbits-1:0] buf_q [p_max_inflight];

    logic             sq;
    logic [UsedW-1:0] used;
    logic             credit;
    logic             drop_mode;
    logic             no_inflight;
    logic             buf_empty;
    logic             issue;
    logic             resp_fire;
    logic             resp_live;
    logic             resp_dec;
    logic             bypass;
    logic             enq;
    logic             deq;

    // Handshake outputs; all forced low while reset is held.
    always_comb begin
        sq          = squash_i | (domain_i != dom_q);
        used        = {1'b0, inflight_q} + {1'b0, occ_q};
        credit      = used < MaxUsed;
        drop_mode   = drop_q != '0;
        no_inflight = inflight_q == '0;
        buf_empty   = occ_q == '0;

        creq_rdy_o  = !reset_i & mreq_rdy_i & credit;
        mreq_val_o  = !reset_i & creq_val_i & credit;
        issue       = creq_val_i & creq_rdy_o;

        // A response with nothing in flight is a protocol error; it is
        // swallowed even when the buffer is full so the bus cannot lock up.
        mresp_rdy_o = !reset_i & (drop_mode | (occ_q < MaxCnt) | (no_inflight & mresp_val_i));
        resp_fire   = mresp_val_i & mresp_rdy_o;
        // Response belongs to a fetch that survives this cycle.
        resp_live   = !drop_mode & !no_inflight & !sq;

        cresp_val_o = !reset_i & !sq & (!buf_empty | (mresp_val_i & resp_live));
        cresp_msg_o = buf_empty ? mresp_msg_i : buf_q[head_q];

        bypass      = resp_fire & resp_live & buf_empty & cresp_rdy_i;
        enq         = resp_fire & resp_live & !bypass;
        deq         = cresp_val_o & cresp_rdy_i & !buf_empty;
        resp_dec    = resp_fire & !no_inflight;
    end

    // Counter and buffer-pointer next state.
    always_comb begin
        inflight_d = inflight_q + p_cnt_nbits'(issue) - p_cnt_nbits'(resp_dec);

        if (sq) begin
            // Everything issued before this cycle is dead; the response
            // arriving now (if any) is one of them.
            drop_d = inflight_q - p_cnt_nbits'(resp_dec);
        end else begin
            drop_d = drop_q - p_cnt_nbits'(resp_fire & drop_mode);
        end

        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (sq) begin
            occ_d  = '0;
            head_d = '0;
            tail_d = '0;
        end else begin
            occ_d = occ_q + p_cnt_nbits'(enq) - p_cnt_nbits'(deq);
            if (enq) begin
                tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrOne;
            end
            if (deq) begin
                head_d = (head_q == LastPtr) ? '0 : head_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dom_q      <= 1'b0;
            inflight_q <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            dom_q      <= domain_i;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Payload storage needs no reset; occupancy says what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            buf_q[tail_q] <= mresp_msg_i;
        end
    end

    assign inflight_o     = inflight_q;
    assign drop_pending_o = drop_q;

    // A response with no fetch outstanding violates the imem protocol.
    a_resp_without_req : assert property (@(posedge clk_i) disable iff (reset_i)
        !(mresp_val_i && no_inflight));

endmodule

// File: tb/tb_plab2_proc_imem_fetch_tracker.sv
module tb_plab2_proc_imem_fetch_tracker;

    localparam int Max = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        domain, squash, creq_val, mreq_rdy, mresp_val, cresp_rdy;
    logic [31:0] mresp_msg;
    logic        creq_rdy_o, mreq_val_o, mresp_rdy_o, cresp_val_o;
    logic [31:0] cresp_msg_o;
    logic [2:0]  inflight_o, drop_pending_o;

    plab2_proc_imem_fetch_tracker #(
        .p_msg_nbits   (32),
        .p_max_inflight(Max)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .domain_i      (domain),
        .squash_i      (squash),
        .creq_val_i    (creq_val),
        .creq_rdy_o    (creq_rdy_o),
        .mreq_val_o    (mreq_val_o),
        .mreq_rdy_i    (mreq_rdy),
        .mresp_msg_i   (mresp_msg),
        .mresp_val_i   (mresp_val),
        .mresp_rdy_o   (mresp_rdy_o),
        .cresp_msg_o   (cresp_msg_o),
        .cresp_val_o   (cresp_val_o),
        .cresp_rdy_i   (cresp_rdy),
        .inflight_o    (inflight_o),
        .drop_pending_o(drop_pending_o)
    );

    always #5 clk = ~clk;

    // Reference model: every issued fetch is a record that also acts as the
    // in-order memory's pending response. Squash marks all older records
    // dead; accepted live responses wait in expq until delivered.
    typedef struct {
        logic [31:0] data;
        int          due;
        bit          live;
    } rec_t;

    rec_t        recs[$];
    logic [31:0] expq[$];
    bit          mdom;
    int          cyc;
    int          lat_lo, lat_hi;
    int          delivered;
    logic [31:0] last_deliv, last_issue;
    int          total, bad;

    bit          e_sq, e_creq_rdy, e_mreq_val, e_mresp_rdy, e_cresp_val;
    logic [31:0] e_cresp_msg;
    int          e_inflight, e_drop;

    function automatic void model_reset();
        recs.delete();
        expq.delete();
        mdom = 1'b0;
    endfunction

    // Drive the memory response from the model and derive expected outputs.
    task automatic present();
        int ndead;
        ndead = 0;
        foreach (recs[i]) if (!recs[i].live) ndead++;
        mresp_val   = (recs.size() > 0) && (recs[0].due <= cyc);
        mresp_msg   = (recs.size() > 0) ? recs[0].data : 32'h0;
        e_sq        = squash || (domain != mdom);
        e_inflight  = recs.size();
        e_drop      = ndead;
        e_creq_rdy  = mreq_rdy && (recs.size() + expq.size() < Max);
        e_mreq_val  = creq_val && (recs.size() + expq.size() < Max);
        e_mresp_rdy = (ndead > 0) || (expq.size() < Max);
        e_cresp_val = !e_sq && ((expq.size() > 0) || (mresp_val && ndead == 0));
        e_cresp_msg = (expq.size() > 0) ? expq[0] : mresp_msg;
    endtask

    // Apply this cycle's transfers to the model, then clock.
    task automatic advance();
        bit   rfire, byp;
        rec_t r, nr;
        rfire = mresp_val && e_mresp_rdy;
        byp   = 1'b0;
        if (e_sq) begin
            foreach (recs[i]) recs[i].live = 1'b0;
            expq.delete();
        end else if (e_cresp_val && cresp_rdy) begin
            if (expq.size() > 0) begin
                last_deliv = expq.pop_front();
            end else begin
                last_deliv = mresp_msg;
                byp = 1'b1;
            end
            delivered++;
        end
        if (rfire) begin
            r = recs.pop_front();
            if (r.live && !byp) expq.push_back(r.data);
        end
        if (creq_val && e_creq_rdy) begin
            nr.data = $urandom;
            nr.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            nr.live = 1'b1;
            recs.push_back(nr);
            last_issue = nr.data;
        end
        mdom = domain;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        creq_val  = 1'b0;
        squash    = 1'b0;
        cresp_rdy = 1'b1;
        n = 0;
        while ((recs.size() > 0 || expq.size() > 0) && n < 200) begin
            present();
            #1;
            advance();
            n++;
        end
        total++;
        if (recs.size() > 0 || expq.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d,%0d left required=0", recs.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        domain    = 1'b0;
        squash    = 1'b0;
        creq_val  = 1'b1;
        mreq_rdy  = 1'b1;
        cresp_rdy = 1'b1;
        mresp_val = 1'b1;
        mresp_msg = 32'h1234;
        lat_lo    = 1;
        lat_hi    = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({creq_rdy_o, mreq_val_o, mresp_rdy_o, cresp_val_o} !== 4'b0) begin
            bad++;
            $display("FAIL reset_hs got=%b required=0000",
                     {creq_rdy_o, mreq_val_o, mresp_rdy_o, cresp_val_o});
        end
        reset     = 1'b0;
        creq_val  = 1'b0;
        mresp_val = 1'b0;
        model_reset();
        cyc = 0;
        #1;
        total++;
        if (inflight_o !== 3'd0 || drop_pending_o !== 3'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d/%0d required=0/0", inflight_o, drop_pending_o);
        end
    endtask

    task automatic test_streaming();
        int issued, peak, n;
        lat_lo = 2; lat_hi = 2;
        mreq_rdy = 1'b1; cresp_rdy = 1'b1; squash = 1'b0;
        issued = 0; peak = 0; n = 0; delivered = 0;
        while (delivered < 8 && n < 40) begin
            creq_val = issued < 8;
            present();
            #1;
            total++;
            if (creq_val && creq_rdy_o !== 1'b1) begin
                bad++;
                $display("FAIL stream_stall got=%b required=1", creq_rdy_o);
            end
            if (e_cresp_val) begin
                total++;
                if (cresp_val_o !== 1'b1 || cresp_msg_o !== e_cresp_msg) begin
                    bad++;
                    $display("FAIL stream_msg got=%b/%h required=1/%h",
                             cresp_val_o, cresp_msg_o, e_cresp_msg);
                end
            end
            if (int'(inflight_o) > peak) peak = inflight_o;
            if (creq_val && e_creq_rdy) issued++;
            advance();
            n++;
        end
        total++;
        if (delivered != 8 || peak != 2) begin
            bad++;
            $display("FAIL stream_summary got=%0d delivered peak %0d required=8 peak 2",
                     delivered, peak);
        end
        drain();
    endtask

    task automatic test_credit();
        int issued, stall_at, rc;
        lat_lo = 10; lat_hi = 10;
        mreq_rdy = 1'b1; cresp_rdy = 1'b1; squash = 1'b0;
        issued = 0; stall_at = -1; rc = -1;
        for (int c = 0; c < 16; c++) begin
            creq_val = 1'b1;
            present();
            #1;
            total++;
            if (creq_rdy_o !== e_creq_rdy) begin
                bad++;
                $display("FAIL credit_rdy got=%b required=%b", creq_rdy_o, e_creq_rdy);
            end
            if (stall_at < 0 && creq_rdy_o === 1'b0) begin
                stall_at = c;
                total++;
                if (issued != 4 || inflight_o !== 3'd4) begin
                    bad++;
                    $display("FAIL credit_limit got=%0d issues inflight %0d required=4/4",
                             issued, inflight_o);
                end
            end
            if (rc >= 0 && c == rc + 1) begin
                total++;
                if (creq_rdy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL credit_resume got=%b required=1", creq_rdy_o);
                end
            end
            if (rc < 0 && mresp_val && e_mresp_rdy) rc = c;
            if (e_creq_rdy) issued++;
            advance();
        end
        total++;
        if (stall_at < 0 || rc < 0) begin
            bad++;
            $display("FAIL credit_events got=%0d/%0d required=nonneg", stall_at, rc);
        end
        drain();
    endtask

    task automatic test_squash();
        logic [31:0] live_data;
        int          discards, n;
        lat_lo = 8; lat_hi = 8;
        mreq_rdy = 1'b1; cresp_rdy = 1'b1;
        delivered = 0; discards = 0;
        for (int c = 0; c < 6; c++) begin
            creq_val = (c < 3) || (c == 5);
            squash   = (c == 5);
            present();
            #1;
            if (c == 5) begin
                total++;
                if (inflight_o !== 3'd3 || cresp_val_o !== 1'b0) begin
                    bad++;
                    $display("FAIL squash_cycle got=%0d/%b required=3/0", inflight_o, cresp_val_o);
                end
            end
            advance();
        end
        live_data = last_issue;
        creq_val = 1'b0; squash = 1'b0;
        present();
        #1;
        total++;
        if (drop_pending_o !== 3'd3) begin
            bad++;
            $display("FAIL squash_drop got=%0d required=3", drop_pending_o);
        end
        n = 0;
        while (delivered == 0 && n < 40) begin
            present();
            #1;
            if (mresp_val && e_drop > 0) begin
                discards++;
                total++;
                if (mresp_rdy_o !== 1'b1 || cresp_val_o !== 1'b0) begin
                    bad++;
                    $display("FAIL squash_discard got=%b/%b required=1/0", mresp_rdy_o, cresp_val_o);
                end
            end
            advance();
            n++;
        end
        total++;
        if (delivered != 1 || last_deliv !== live_data || discards != 3) begin
            bad++;
            $display("FAIL squash_live got=%0d %h disc %0d required=1 %h disc 3",
                     delivered, last_deliv, discards, live_data);
        end
        drain();
    endtask

    task automatic test_squash_resp();
        int n;
        mreq_rdy = 1'b1; cresp_rdy = 1'b0; squash = 1'b0;
        for (int c = 0; c < 4; c++) begin
            creq_val = 1'b1;
            lat_lo = (c < 2) ? 1 : 6;
            lat_hi = lat_lo;
            present();
            #1;
            advance();
        end
        creq_val = 1'b0;
        n = 0;
        present();
        while (!(mresp_val && recs.size() == 2 && expq.size() == 2) && n < 20) begin
            #1;
            advance();
            present();
            n++;
        end
        squash = 1'b1;
        present();
        #1;
        total++;
        if (mresp_rdy_o !== 1'b1 || cresp_val_o !== 1'b0 || inflight_o !== 3'd2) begin
            bad++;
            $display("FAIL sqresp_cycle got=%b/%b/%0d required=1/0/2",
                     mresp_rdy_o, cresp_val_o, inflight_o);
        end
        advance();
        squash = 1'b0;
        present();
        #1;
        total++;
        if (drop_pending_o !== 3'd1 || inflight_o !== 3'd1 || cresp_val_o !== 1'b0) begin
            bad++;
            $display("FAIL sqresp_after got=%0d/%0d/%b required=1/1/0",
                     drop_pending_o, inflight_o, cresp_val_o);
        end
        delivered = 0;
        drain();
        total++;
        if (delivered != 0) begin
            bad++;
            $display("FAIL sqresp_flushed got=%0d required=0", delivered);
        end
    endtask

    task automatic test_domain();
        mreq_rdy = 1'b1; cresp_rdy = 1'b0; squash = 1'b0; domain = 1'b0;
        for (int c = 0; c < 3; c++) begin
            creq_val = 1'b1;
            lat_lo = (c == 0) ? 1 : 6;
            lat_hi = lat_lo;
            present();
            #1;
            advance();
        end
        creq_val = 1'b0;
        domain   = 1'b1;
        present();
        #1;
        total++;
        if (cresp_val_o !== 1'b0 || e_cresp_val) begin
            bad++;
            $display("FAIL domain_cycle got=%b required=0", cresp_val_o);
        end
        advance();
        present();
        #1;
        total++;
        if (drop_pending_o !== 3'd2) begin
            bad++;
            $display("FAIL domain_drop got=%0d required=2", drop_pending_o);
        end
        creq_val = 1'b1; cresp_rdy = 1'b1; lat_lo = 2; lat_hi = 2;
        present();
        #1;
        advance();
        delivered = 0;
        drain();
        total++;
        if (delivered != 1 || last_deliv !== last_issue) begin
            bad++;
            $display("FAIL domain_new got=%0d %h required=1 %h", delivered, last_deliv, last_issue);
        end
    endtask

    task automatic test_backpressure_reset();
        int n;
        mreq_rdy = 1'b1; cresp_rdy = 1'b0; squash = 1'b0;
        lat_lo = 1; lat_hi = 1;
        creq_val = 1'b1;
        n = 0;
        present();
        while (expq.size() < 4 && n < 20) begin
            #1;
            advance();
            present();
            n++;
        end
        #1;
        total++;
        if (mresp_rdy_o !== 1'b0 || creq_rdy_o !== 1'b0 || cresp_val_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_full got=%b/%b/%b required=0/0/1", mresp_rdy_o, creq_rdy_o, cresp_val_o);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({mreq_val_o, creq_rdy_o, mresp_rdy_o, cresp_val_o} !== 4'b0 ||
            inflight_o !== 3'd0 || drop_pending_o !== 3'd0) begin
            bad++;
            $display("FAIL async_reset got=%b %0d %0d required=0000 0 0",
                     {mreq_val_o, creq_rdy_o, mresp_rdy_o, cresp_val_o}, inflight_o, drop_pending_o);
        end
        @(posedge clk);
        #2;
        reset = 1'b0; domain = 1'b0; creq_val = 1'b0;
        model_reset();
        present();
        #1;
        total++;
        if (inflight_o !== 3'd0 || drop_pending_o !== 3'd0 || cresp_val_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got=%0d/%0d/%b required=0/0/0",
                     inflight_o, drop_pending_o, cresp_val_o);
        end
        advance();
    endtask

    task automatic test_random();
        lat_lo = 1; lat_hi = 6;
        for (int c = 0; c < 600; c++) begin
            creq_val  = ($urandom_range(99) < 60);
            mreq_rdy  = ($urandom_range(99) < 80);
            cresp_rdy = ($urandom_range(99) < 70);
            squash    = ($urandom_range(99) < 5);
            if ($urandom_range(99) < 3) domain = ~domain;
            present();
            #1;
            total++;
            if (creq_rdy_o !== e_creq_rdy || mreq_val_o !== e_mreq_val ||
                mresp_rdy_o !== e_mresp_rdy || cresp_val_o !== e_cresp_val ||
                inflight_o !== 3'(e_inflight) || drop_pending_o !== 3'(e_drop)) begin
                bad++;
                $display("FAIL rand_ctl c=%0d got=%b%b%b%b %0d %0d required=%b%b%b%b %0d %0d", c,
                         creq_rdy_o, mreq_val_o, mresp_rdy_o, cresp_val_o, inflight_o,
                         drop_pending_o, e_creq_rdy, e_mreq_val, e_mresp_rdy, e_cresp_val,
                         e_inflight, e_drop);
            end
            if (e_cresp_val) begin
                total++;
                if (cresp_msg_o !== e_cresp_msg) begin
                    bad++;
                    $display("FAIL rand_msg c=%0d got=%h required=%h", c, cresp_msg_o, e_cresp_msg);
                end
            end
            advance();
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        delivered = 0;
        last_deliv = '0;
        last_issue = '0;
        test_reset();
        test_streaming();
        test_credit();
        test_squash();
        test_squash_resp();
        test_domain();
        test_backpressure_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plab2_proc_imem_fetch_tracker.md
Name: plab2_proc_imem_fetch_tracker

Overview:
- Sits between the pipelined processor's fetch control and the instruction-memory request/response ports.
- Generalises the single-response drop unit and bypass queue pair into one block:
  - allows up to p_max_inflight outstanding fetches;
  - discards any number of squashed responses;
  - buffers live responses;
  - auto-squashes all in-flight fetches when the security domain changes.

Parameters:
- p_msg_nbits, 32: width of the response message passed through.
- p_max_inflight, 4: maximum outstanding requests plus buffered responses (credits). Must be >= 1.
- p_cnt_nbits, $clog2(p_max_inflight+1): counter width. Derived; not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- domain  in  1  current security domain of the fetch stream
- squash  in  1  ctrl redirect; kills every fetch issued before this cycle
- creq_val  in  1  ctrl wants to issue a fetch
- creq_rdy  out  1  fetch may issue
- mreq_val  out  1  request valid to imem
- mreq_rdy  in  1  imem accepts request
- mresp_msg  in  p_msg_nbits  imem response message
- mresp_val  in  1  imem response valid
- mresp_rdy  out  1  block accepts imem response
- cresp_msg  out  p_msg_nbits  live response to ctrl
- cresp_val  out  1  live response valid
- cresp_rdy  in  1  ctrl accepts response
- inflight  out  p_cnt_nbits  requests issued, response not yet received
- drop_pending  out  p_cnt_nbits  responses still to be discarded

Behaviour:
- Reset:
  - inflight, drop_pending and buffer occupancy (occ) = 0; buffer empty; dom_q = 0.
  - While reset is high: mreq_val = 0, creq_rdy = 0, mresp_rdy = 0, cresp_val = 0.
- Effective squash: sq = squash | (domain != dom_q). dom_q <= domain every cycle.
- Credits: used = inflight + occ.
  - mreq_val = creq_val & (used < p_max_inflight).
  - creq_rdy = mreq_rdy & (used < p_max_inflight).
  - Issue fire = creq_val & creq_rdy. Pure combinational pass-through; zero latency.
- Request issued in the same cycle as sq is live (post-redirect fetch). It is not dropped.
- inflight_next = inflight + issue fire − mresp fire.
- Drop mode (drop_pending > 0):
  - mresp_rdy = 1.
  - Each mresp fire is discarded and drop_pending decrements.
  - Nothing is enqueued or forwarded.
- Live mode (drop_pending == 0): mresp_rdy = (occ < p_max_inflight).
- On sq:
  - drop_pending_next = inflight − (mresp fire ? 1 : 0).
  - A response arriving in the sq cycle is discarded.
  - The buffer is flushed (occ_next = 0).
  - cresp_val is forced to 0 that cycle.
- Live response path, bypass-queue semantics:
  - If the buffer is empty and cresp_rdy = 1, mresp_msg goes directly to cresp_msg in the same cycle (0-cycle latency) and is not enqueued.
  - Otherwise the response is enqueued into a circular FIFO of depth p_max_inflight. Head and tail pointers wrap modulo the depth.
  - With a non-empty buffer, cresp presents the head; order is strict FIFO.
- Simultaneous enqueue and dequeue at full: legal; occ unchanged. Cannot overflow, because credits bound inflight + occ.
- mresp_val with inflight == 0 is a protocol error:
  - simulation assertion fires;
  - response is accepted (mresp_rdy = 1) and discarded;
  - counters saturate at 0.
- Counters never wrap; p_cnt_nbits covers 0..p_max_inflight.
- Reset asserted mid-operation clears all state immediately, regardless of clk. Responses for pre-reset requests are the memory system's responsibility; the memory is reset together with this block.
- drop_pending and inflight are driven from registers only.

Test Plan:
- Basic streaming: p_max_inflight=4, mreq_rdy=1, imem latency 2; issue 8 fetches → 8 responses in order on cresp. inflight peaks at 2; no stalls.
- Credit limit: imem latency 10, cresp_rdy=1; issue continuously → creq_rdy drops after 4 issues; inflight=4; issue resumes the cycle after the first response.
- Squash with 3 in flight: squash on cycle 5, new fetch in the same cycle → drop_pending=3. The next 3 responses are discarded with mresp_rdy=1. The 4th response (the new fetch) appears on cresp.
- Squash plus same-cycle response, inflight=2: one response fires with squash → drop_pending=1. Both old responses are discarded; buffer is flushed (occ 2→0).
- Domain flip: domain toggles 0→1 with 2 in flight → behaves as squash. drop_pending=2; cresp_val=0 that cycle; a subsequent domain-1 fetch is delivered.
- Backpressure and reset: cresp_rdy=0 with 4 responses buffered → mresp_rdy=0 and creq_rdy=0. Assert reset asynchronously mid-cycle → all outputs go to 0 immediately; inflight=0, drop_pending=0 after release.
